// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter
//   Owns the character buffer shown on the seven-segment display. It takes
//   three requesters (append from the Morse decoder, backspace, clear) through
//   req/ack handshakes, grants one at a time (clear > backspace > append), and
//   applies exactly one edit per grant.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   append_req/append_char/ack   append a segment code (sampled at grant)
//   bksp_req/bksp_ack            remove the newest character
//   clr_req/clr_ack              blank the whole buffer
//   buf_out                      packed buffer, slot 0 = [CW-1:0] = newest
//   count, full, empty           occupancy and its status flags
//   overflow                     1-cycle pulse with the ack, oldest char lost
//   busy                         a request is being served
module text_buffer_arbiter #(
  parameter int              NCHAR = 8,
  parameter int              CW    = 8,
  parameter logic [CW-1:0]   BLANK = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                append_req,
  input  logic [CW-1:0]       append_char,
  output logic                append_ack,
  input  logic                bksp_req,
  output logic                bksp_ack,
  input  logic                clr_req,
  output logic                clr_ack,
  output logic [NCHAR*CW-1:0] buf_out,
  output logic [3:0]          count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                busy
);

  localparam logic [3:0] NCHAR_C = 4'(NCHAR);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK, S_REL} state_t;
  typedef enum logic [1:0] {G_NONE, G_CLR, G_BKSP, G_APP} grant_t;

  state_t               state_q, state_d;
  grant_t               grant_q, grant_d;
  logic [CW-1:0]        char_q, char_d;
  logic [NCHAR*CW-1:0]  buf_q, buf_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 grant_req;

  // Level of the request currently holding the grant.
  always_comb begin
    grant_req = 1'b0;
    case (grant_q)
      G_CLR:   grant_req = clr_req;
      G_BKSP:  grant_req = bksp_req;
      G_APP:   grant_req = append_req;
      default: grant_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    char_d  = char_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        char_d = append_char;
        if (clr_req) begin
          grant_d = G_CLR;
          state_d = S_EXEC;
        end else if (bksp_req) begin
          grant_d = G_BKSP;
          state_d = S_EXEC;
        end else if (append_req) begin
          grant_d = G_APP;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ovf_d   = 1'b0;
        state_d = S_ACK;
        case (grant_q)
          G_CLR: begin
            buf_d = {NCHAR{BLANK}};
            cnt_d = 4'd0;
          end
          G_BKSP: begin
            if (cnt_q != 4'd0) begin
              buf_d = {BLANK, buf_q[NCHAR*CW-1:CW]};
              cnt_d = cnt_q - 4'd1;
            end
          end
          G_APP: begin
            // A blank code would be indistinguishable from an empty slot,
            // so it is acknowledged but never stored.
            if (char_q != BLANK) begin
              buf_d = {buf_q[(NCHAR-1)*CW-1:0], char_q};
              if (cnt_q == NCHAR_C) ovf_d = 1'b1;
              else                  cnt_d = cnt_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
      S_ACK: state_d = S_REL;
      S_REL: begin
        // Only the granted request is watched; others stay pending.
        if (!grant_req) begin
          state_d = S_IDLE;
          grant_d = G_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= G_NONE;
      char_q     <= BLANK;
      buf_q      <= {NCHAR{BLANK}};
      cnt_q      <= 4'd0;
      ovf_q      <= 1'b0;
      append_ack <= 1'b0;
      bksp_ack   <= 1'b0;
      clr_ack    <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      char_q     <= char_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      // Acks are registered off the ACK state, so they are visible during
      // the cycle after it (edges N+2..N+3 for a request seen at edge N).
      append_ack <= (state_q == S_ACK) && (grant_q == G_APP);
      bksp_ack   <= (state_q == S_ACK) && (grant_q == G_BKSP);
      clr_ack    <= (state_q == S_ACK) && (grant_q == G_CLR);
      overflow   <= (state_q == S_ACK) && ovf_q;
      busy       <= (state_d != S_IDLE);
      full       <= (cnt_d == NCHAR_C);
      empty      <= (cnt_d == 4'd0);
    end
  end

  assign buf_out = buf_q;
  assign count   = cnt_q;

endmodule
